key_judge: RTL and testbench
============================

# key_judge

Clocked, multi-player successor of the single-player key checker in the race core. It takes each player's raw left/right keys, synchronises and edge-detects them, and judges each new press against that player's next-box bit from the shifter. A correct press produces a one-cycle `correctkey` pulse, which drives score decrement and box shift. A wrong press produces a `wrongkey` pulse followed by a configurable lockout penalty. One instance sits between the keypad inputs and the per-player score/shifter logic.

## Interface
- `NUM_PLAYERS`, default 2: number of independent player channels.
- `LOCKOUT_CYCLES`, default 50_000_000: penalty length in clk cycles after a wrong press. 0 means no lockout.
- `DEBOUNCE_CYCLES`, default 250_000: number of stable cycles a key needs before its level is accepted. Used only when `KEY_DEBOUNCE_EN` is defined.
- `clk` input, 1 bit: system clock. All logic is rising-edge.
- `resetn` input, 1 bit: reset, synchronous, active-low.
- `enable` input, 1 bit: race running. When low, all judging is suppressed.
- `box` input, `NUM_PLAYERS` bits: per-player next box. 1 = right, 0 = left. Synchronous to clk.
- `left` input, `NUM_PLAYERS` bits: raw asynchronous left keys, active-high.
- `right` input, `NUM_PLAYERS` bits: raw asynchronous right keys, active-high.
- `correctkey` output, `NUM_PLAYERS` bits: one-cycle pulse per correct press.
- `wrongkey` output, `NUM_PLAYERS` bits: one-cycle pulse per wrong press.
- `locked` output, `NUM_PLAYERS` bits: high while the player is in LOCKOUT.

## Operation
- Each player channel is identical and independent. There is no cross-player interaction.
- Key path: 2-flop synchroniser, then optional debounce filter, then 1-flop history register for rising-edge detection on L and R.
- Per-player FSM has three states.
  - IDLE:
    - Rising edge on exactly one key with no level on the other key: if the key matches `box` (R with box=1, L with box=0), pulse `correctkey` and go to WAIT_REL.
    - Otherwise, pulse `wrongkey`, load the lockout counter with `LOCKOUT_CYCLES`, and go to LOCKOUT.
    - Both keys rising in the same cycle, or a rise while the other key is held, is a wrong press.
  - WAIT_REL: no pulses. Return to IDLE once both filtered keys are low. Holding a key never re-triggers a judgement.
  - LOCKOUT: `locked`=1. The counter decrements each cycle, saturating at 0. Go to IDLE when the counter is 0 and both keys are low. Presses during LOCKOUT are ignored; they neither pulse nor extend the counter.
- If `LOCKOUT_CYCLES`=0, a wrong press pulses `wrongkey` and goes to WAIT_REL instead of LOCKOUT.
- `box` is sampled in the same cycle the edge is detected.
- `enable`=0: the FSM is forced to IDLE, counters clear, all outputs are 0. Synchroniser and history flops keep running, so a key held across the enable rise does not count as a press.
- Counter width is `$clog2(LOCKOUT_CYCLES+1)`, minimum 1 bit.
- `correctkey` and `wrongkey` are mutually exclusive per player in every cycle.

## Timing
- Reset (`resetn`=0 at a clk edge): all FSMs go to IDLE, counters and history flops clear, and `correctkey`, `wrongkey`, `locked` are 0 in the following cycle. Reset mid-lockout or mid-press aborts with no pulse.
- Without debounce: a key first sampled high at edge k produces its pulse during cycle k+3, that is, 2 synchroniser cycles plus 1 edge-detect cycle, with a registered output.
- With debounce: latency is k+3+`DEBOUNCE_CYCLES`.
- Pulses are exactly 1 clk wide.
- The earliest next judgement is 1 cycle after both keys are seen low in WAIT_REL.
- `locked` rises in the same cycle as `wrongkey`. It falls in the cycle the FSM enters IDLE, which is at least `LOCKOUT_CYCLES` cycles later.

## Configuration
- `KEY_DEBOUNCE_EN` defined: each synchronised key passes through a counter filter. The filtered level changes only after the raw synchronised level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- `KEY_DEBOUNCE_EN` undefined: the filter is omitted and the synchronised level feeds edge detection directly. The `DEBOUNCE_CYCLES` parameter is ignored.

## Structure
- Shared package `pyon_pkg` holds:
  - the FSM typedef `judge_state_t` with states IDLE, WAIT_REL, LOCKOUT;
  - the constants `BOX_LEFT`=0 and `BOX_RIGHT`=1.
- Sub-module `key_debounce`: one bit wide, parametrised by `DEBOUNCE_CYCLES`, holding the synchroniser and filter. It is instantiated 2×`NUM_PLAYERS` times from a generate loop.

## Test plan
- box[0]=1, press right[0] for 10 cycles (no debounce) -> `correctkey[0]`=1 for exactly 1 cycle at k+3. `wrongkey` stays 0. Holding produces no second pulse.
- box[0]=0, press right[0], `LOCKOUT_CYCLES`=20 -> `wrongkey[0]` pulses. `locked[0]` stays high for ≥20 cycles. A left press during lockout produces no pulse.
- left[1] and right[1] rising in the same cycle -> `wrongkey[1]` pulse. Player 0 outputs are unaffected.
- `enable`=0 while pressing the correct key -> no pulses. Raise `enable` while the key is still held -> still no pulse until release and re-press.
- Drive `resetn`=0 for 1 cycle mid-lockout -> `locked`=0 next cycle. A correct press afterwards pulses `correctkey` normally.
- With `KEY_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=8, and a 5-cycle glitch on right[0] -> no pulse. A 12-cycle press -> one pulse at k+11.

Source files
------------

// File: rtl/pyon_pkg.sv
// Shared types and constants for the race-core key judging logic.
package pyon_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_REL = 2'd1,
      LOCKOUT  = 2'd2
   } judge_state_t;

   localparam logic BOX_LEFT  = 1'b0;
   localparam logic BOX_RIGHT = 1'b1;

   // True when the pressed key points the same way as the next box.
   function automatic logic key_matches(input logic box_bit, input logic right_pressed);
      return right_pressed ? (box_bit == BOX_RIGHT) : (box_bit == BOX_LEFT);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One-bit key conditioner: 2-flop synchroniser plus a stable-count filter.
// The filter is built only when KEY_DEBOUNCE_EN is defined; otherwise the synchronised level passes straight through.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 250_000
) (
   input  logic clk,
   input  logic resetn,
   input  logic key,
   output logic level
);

`ifdef KEY_DEBOUNCE_EN
   localparam int FILTER_LEN = DEBOUNCE_CYCLES;
`else
   localparam int FILTER_LEN = 0;
`endif

   logic meta_r;
   logic sync_r;

   // Two-stage synchroniser for the asynchronous raw key.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= key;
         sync_r <= meta_r;
      end
   end

   if (FILTER_LEN == 0) begin : g_direct
      assign level = sync_r;
   end else begin : g_filter
      localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
      localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

      logic [CNT_W-1:0] cnt_r;
      logic             filt_r;

      // Accept a new level only after FILTER_LEN consecutive disagreeing cycles.
      always_ff @(posedge clk) begin
         if (!resetn) begin
            cnt_r  <= CNT_ZERO;
            filt_r <= 1'b0;
         end else if (sync_r == filt_r) begin
            cnt_r  <= CNT_ZERO;
         end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= CNT_ZERO;
            filt_r <= sync_r;
         end else begin
            cnt_r  <= cnt_r + CNT_ONE;
         end
      end

      assign level = filt_r;
   end

endmodule

// File: rtl/key_judge.sv
// Multi-player key judge: conditions raw keys and scores each new press against that player's next box.
// Defining KEY_DEBOUNCE_EN inserts a stable-count filter in every key path.
module key_judge
   import pyon_pkg::*;
#(
   parameter int NUM_PLAYERS     = 2,
   parameter int LOCKOUT_CYCLES  = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 250_000
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   enable,
   input  logic [NUM_PLAYERS-1:0] box,
   input  logic [NUM_PLAYERS-1:0] left,
   input  logic [NUM_PLAYERS-1:0] right,
   output logic [NUM_PLAYERS-1:0] correctkey,
   output logic [NUM_PLAYERS-1:0] wrongkey,
   output logic [NUM_PLAYERS-1:0] locked
);

   localparam int CNT_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   // With no penalty a wrong press only has to wait for release.
   localparam judge_state_t WRONG_NEXT = (LOCKOUT_CYCLES == 0) ? WAIT_REL : LOCKOUT;

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      logic             left_lvl_s, right_lvl_s;
      logic             left_hist_r, right_hist_r;
      logic             left_rise_r, right_rise_r;
      logic             single_s;
      judge_state_t     state_r, state_s;
      logic [CNT_W-1:0] cnt_r, cnt_s;
      logic             correct_s, wrong_s;
      logic             correct_r, wrong_r, locked_r;

      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
         .clk    (clk),
         .resetn (resetn),
         .key    (left[p]),
         .level  (left_lvl_s)
      );

      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
         .clk    (clk),
         .resetn (resetn),
         .key    (right[p]),
         .level  (right_lvl_s)
      );

      // History and registered rising edges; these keep running while the race is disabled.
      always_ff @(posedge clk) begin
         if (!resetn) begin
            left_hist_r  <= 1'b0;
            right_hist_r <= 1'b0;
            left_rise_r  <= 1'b0;
            right_rise_r <= 1'b0;
         end else begin
            left_hist_r  <= left_lvl_s;
            right_hist_r <= right_lvl_s;
            left_rise_r  <= left_lvl_s & ~left_hist_r;
            right_rise_r <= right_lvl_s & ~right_hist_r;
         end
      end

      // A clean press is one key rising while the other is low; simultaneous rises fail both terms.
      assign single_s = (right_rise_r & ~left_hist_r) | (left_rise_r & ~right_hist_r);

      // Judge FSM next-state and pulse decode.
      always_comb begin
         state_s   = state_r;
         cnt_s     = cnt_r;
         correct_s = 1'b0;
         wrong_s   = 1'b0;
         if (!enable) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
         end else begin
            case (state_r)
               IDLE: begin
                  if (left_rise_r || right_rise_r) begin
                     if (single_s && key_matches(box[p], right_rise_r)) begin
                        correct_s = 1'b1;
                        state_s   = WAIT_REL;
                     end else begin
                        wrong_s   = 1'b1;
                        state_s   = WRONG_NEXT;
                        cnt_s     = CNT_LOAD;
                     end
                  end else begin
                     state_s = IDLE;
                  end
               end
               WAIT_REL: begin
                  if (!left_hist_r && !right_hist_r) begin
                     state_s = IDLE;
                  end else begin
                     state_s = WAIT_REL;
                  end
               end
               LOCKOUT: begin
                  if (cnt_r != CNT_ZERO) begin
                     cnt_s   = cnt_r - CNT_ONE;
                     state_s = LOCKOUT;
                  end else if (!left_hist_r && !right_hist_r) begin
                     state_s = IDLE;
                  end else begin
                     state_s = LOCKOUT;
                  end
               end
               default: begin
                  state_s = IDLE;
                  cnt_s   = CNT_ZERO;
               end
            endcase
         end
      end

      // FSM state, penalty counter and registered outputs.
      always_ff @(posedge clk) begin
         if (!resetn) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            correct_r <= 1'b0;
            wrong_r   <= 1'b0;
            locked_r  <= 1'b0;
         end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            correct_r <= correct_s;
            wrong_r   <= wrong_s;
            locked_r  <= (state_s == LOCKOUT);
         end
      end

      assign correctkey[p] = correct_r;
      assign wrongkey[p]   = wrong_r;
      assign locked[p]     = locked_r;
   end

endmodule

// File: tb/tb_key_judge.sv
// Directed bench for key_judge: a vector table of single presses plus hand sequences for lockout, enable, reset and debounce.
module tb_key_judge;

   localparam int NP   = 2;
   localparam int LOCK = 20;
   localparam int DEB  = 8;
`ifdef KEY_DEBOUNCE_EN
   localparam int LAT  = 3 + DEB;
`else
   localparam int LAT  = 3;
`endif
   localparam int PRESS = LAT + 2;
   localparam int TAIL  = LOCK + LAT + DEB + 12;

   logic          clk;
   logic          resetn;
   logic          enable;
   logic [NP-1:0] box;
   logic [NP-1:0] left;
   logic [NP-1:0] right;
   logic [NP-1:0] correctkey;
   logic [NP-1:0] wrongkey;
   logic [NP-1:0] locked;

   key_judge #(
      .NUM_PLAYERS     (NP),
      .LOCKOUT_CYCLES  (LOCK),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .enable     (enable),
      .box        (box),
      .left       (left),
      .right      (right),
      .correctkey (correctkey),
      .wrongkey   (wrongkey),
      .locked     (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] box;
      logic [1:0] left;
      logic [1:0] right;
      logic       en;
      int         hold;
      logic [1:0] exp_c;
      logic [1:0] exp_w;
   } vec_t;

   vec_t vecs [9];

   int total;
   int bad;
   int c_cnt [NP];
   int w_cnt [NP];
   int c_first [NP];
   int w_first [NP];
   int lock_cnt [NP];
   int excl_bad;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic check_min(input string name, input int act, input int lo);
      total++;
      if (act < lo) begin
         bad++;
         $display("FAIL %s: got %0d want >= %0d", name, act, lo);
      end
   endtask

   task automatic clear_obs();
      for (int p = 0; p < NP; p++) begin
         c_cnt[p]    = 0;
         w_cnt[p]    = 0;
         c_first[p]  = -1;
         w_first[p]  = -1;
         lock_cnt[p] = 0;
      end
      excl_bad = 0;
   endtask

   // Index 0 is the negedge just after the first posedge that samples the new inputs.
   task automatic observe(input int n, input int base);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         for (int p = 0; p < NP; p++) begin
            if (correctkey[p]) begin
               if (c_cnt[p] == 0) c_first[p] = base + j;
               c_cnt[p]++;
            end
            if (wrongkey[p]) begin
               if (w_cnt[p] == 0) w_first[p] = base + j;
               w_cnt[p]++;
            end
            if (locked[p]) lock_cnt[p]++;
            if (correctkey[p] && wrongkey[p]) excl_bad++;
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      clear_obs();
      enable = v.en;
      box    = v.box;
      left   = v.left;
      right  = v.right;
      observe(v.hold, 0);
      left   = 2'b00;
      right  = 2'b00;
      observe(TAIL, v.hold);
      enable = 1'b1;
      for (int p = 0; p < NP; p++) begin
         check($sformatf("%s p%0d correct count", name, p), c_cnt[p], v.exp_c[p] ? 1 : 0);
         check($sformatf("%s p%0d wrong count", name, p), w_cnt[p], v.exp_w[p] ? 1 : 0);
         if (v.exp_c[p]) check($sformatf("%s p%0d correct latency", name, p), c_first[p], LAT);
         if (v.exp_w[p]) begin
            check($sformatf("%s p%0d wrong latency", name, p), w_first[p], LAT);
            check($sformatf("%s p%0d locked rise", name, p), w_first[p] >= 0 ? 1 : 0, 1);
            check_min($sformatf("%s p%0d locked length", name, p), lock_cnt[p], LOCK);
         end else begin
            check($sformatf("%s p%0d locked length", name, p), lock_cnt[p], 0);
         end
      end
      check($sformatf("%s exclusive", name), excl_bad, 0);
      check($sformatf("%s locked at end", name), int'(locked), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      total  = 0;
      bad    = 0;
      resetn = 1'b0;
      enable = 1'b1;
      box    = 2'b00;
      left   = 2'b00;
      right  = 2'b00;

      //            box    left   right  en    hold exp_c  exp_w
      vecs[0] = '{2'b01, 2'b00, 2'b01, 1'b1, 10, 2'b01, 2'b00};
      vecs[1] = '{2'b00, 2'b01, 2'b00, 1'b1, 10, 2'b01, 2'b00};
      vecs[2] = '{2'b00, 2'b00, 2'b01, 1'b1, 10, 2'b00, 2'b01};
      vecs[3] = '{2'b10, 2'b00, 2'b10, 1'b1, 10, 2'b10, 2'b00};
      vecs[4] = '{2'b00, 2'b10, 2'b10, 1'b1, 10, 2'b00, 2'b10};
      vecs[5] = '{2'b11, 2'b00, 2'b11, 1'b1, 10, 2'b11, 2'b00};
      vecs[6] = '{2'b01, 2'b01, 2'b00, 1'b1, 10, 2'b00, 2'b01};
      vecs[7] = '{2'b01, 2'b00, 2'b01, 1'b0, 10, 2'b00, 2'b00};
      vecs[8] = '{2'b10, 2'b01, 2'b10, 1'b1, 10, 2'b11, 2'b00};

      repeat (3) @(negedge clk);
      check("reset correctkey", int'(correctkey), 0);
      check("reset wrongkey", int'(wrongkey), 0);
      check("reset locked", int'(locked), 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Presses during lockout are ignored, then the player judges normally again.
      clear_obs();
      box   = 2'b00;
      right = 2'b01;
      observe(PRESS, 0);
      right = 2'b00;
      observe(3, PRESS);
      left  = 2'b01;
      observe(PRESS, PRESS + 3);
      left  = 2'b00;
      observe(TAIL, 2 * PRESS + 3);
      check("lockout wrong count", w_cnt[0], 1);
      check("lockout correct count", c_cnt[0], 0);
      check_min("lockout locked length", lock_cnt[0], LOCK);
      check("lockout released", int'(locked[0]), 0);
      v = '{2'b00, 2'b01, 2'b00, 1'b1, PRESS, 2'b01, 2'b00};
      run_vec(v, "after lockout");

      // Key held across the enable rise is not a press.
      clear_obs();
      enable = 1'b0;
      box    = 2'b01;
      right  = 2'b01;
      observe(PRESS, 0);
      enable = 1'b1;
      observe(LAT + 10, PRESS);
      right  = 2'b00;
      observe(TAIL, PRESS + LAT + 10);
      check("enable held correct", c_cnt[0], 0);
      check("enable held wrong", w_cnt[0], 0);
      v = '{2'b01, 2'b00, 2'b01, 1'b1, PRESS, 2'b01, 2'b00};
      run_vec(v, "enable repress");

      // Reset in the middle of a lockout.
      clear_obs();
      box   = 2'b00;
      right = 2'b01;
      observe(PRESS, 0);
      right = 2'b00;
      observe(2, PRESS);
      check("mid lockout locked", int'(locked[0]), 1);
      resetn = 1'b0;
      @(negedge clk);
      check("reset lockout locked", int'(locked), 0);
      check("reset lockout wrongkey", int'(wrongkey), 0);
      resetn = 1'b1;
      @(negedge clk);
      v = '{2'b01, 2'b00, 2'b01, 1'b1, PRESS, 2'b01, 2'b00};
      run_vec(v, "after reset");

`ifdef KEY_DEBOUNCE_EN
      v = '{2'b01, 2'b00, 2'b01, 1'b1, 5, 2'b00, 2'b00};
      run_vec(v, "glitch");
      v = '{2'b01, 2'b00, 2'b01, 1'b1, 12, 2'b01, 2'b00};
      run_vec(v, "debounced press");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
